int_issue_queue: RTL
====================

INT_ISSUE_QUEUE -- requirements
Module: int_issue_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: number of queue entries; a power of two and at least 2.
REQ-002 Port clk SHALL be input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be input, 1 bit: reset, asynchronous, active-high.
REQ-004 Port i_enq_valid SHALL be input, 1 bit: upstream presents a command.
REQ-005 Port o_enq_ready SHALL be output, 1 bit: the queue accepts a command this cycle.
REQ-006 Port i_enq_command SHALL be input, execution_command_t: the command to enqueue.
REQ-007 Port i_flush SHALL be input, 1 bit: discard all queued commands (mispredict/exception).
REQ-008 Port o_issue_valid SHALL be output, 1 bit: the head command is presented to the integer execution unit; it drives that unit's i_valid.
REQ-009 Port o_issue_command SHALL be output, execution_command_t: the head command; it drives that unit's i_command.
REQ-010 Port i_issue_ready SHALL be input, 1 bit: the downstream execution/writeback slot accepts the command.
REQ-011 Port o_count SHALL be output, $clog2(DEPTH+1) bits: number of stored entries.
REQ-012 Ports o_full and o_empty SHALL be outputs, 1 bit each: o_full is (o_count==DEPTH) and o_empty is (o_count==0).

Function
REQ-013 The queue SHALL be a circular buffer with a head pointer and a tail pointer, each $clog2(DEPTH) bits, that wrap from DEPTH-1 to 0.
REQ-014 An enqueue SHALL occur when i_enq_valid && o_enq_ready; the command is written at the tail and the tail advances by 1.
REQ-015 o_enq_ready SHALL be !o_full && !i_flush; enqueue into a full queue is never accepted, even if a dequeue occurs in the same cycle.
REQ-016 With bypass disabled, o_issue_valid SHALL be !o_empty && !i_flush, and o_issue_command SHALL be the entry at the head.
REQ-017 A dequeue SHALL occur when o_issue_valid && i_issue_ready; the head advances by 1.
REQ-018 An enqueued command SHALL appear at the head no earlier than the next cycle (one-cycle latency) when bypass is disabled.
REQ-019 Simultaneous enqueue and dequeue SHALL leave o_count unchanged and advance both pointers.
REQ-020 o_count SHALL be incremented on enqueue-only, decremented on dequeue-only, and unchanged otherwise.
REQ-021 When i_flush is high, the next edge SHALL set o_count, head and tail to 0; a flush overrides any enqueue or dequeue in that cycle.
REQ-022 Commands SHALL issue in strict enqueue order; no entry is ever duplicated or dropped except by flush.
REQ-023 o_issue_command SHALL be held stable while o_issue_valid is high and i_issue_ready is low.

Reset
REQ-024 While rst is high, head, tail and o_count SHALL be 0, o_empty SHALL be 1, and o_full, o_issue_valid and o_enq_ready SHALL be 0.
REQ-025 Storage array contents SHALL NOT require reset; o_issue_command is don't-care while o_issue_valid is 0.
REQ-026 Reset asserted mid-operation SHALL discard all entries immediately, asynchronously to clk.
REQ-027 o_enq_ready SHALL rise on the first clk edge after rst deasserts.

Configuration
REQ-028 Macro INT_ISSUE_BYPASS_EN SHALL control a bypass path; when it is undefined, REQ-016 and REQ-018 apply unchanged.
REQ-029 With INT_ISSUE_BYPASS_EN defined, if o_empty && i_enq_valid && !i_flush, the block SHALL set o_issue_valid to 1 and o_issue_command to i_enq_command in the same cycle.
REQ-030 With INT_ISSUE_BYPASS_EN defined, if i_issue_ready is also high in that cycle, the command SHALL be consumed without being written, and o_count SHALL stay 0.
REQ-031 With INT_ISSUE_BYPASS_EN defined, if i_issue_ready is low in that cycle, the command SHALL be written normally and present at the head the next cycle.

Verification
REQ-032 Scenario: DEPTH=4, i_issue_ready=0, enqueue commands A,B,C,D on consecutive cycles -> o_count reaches 4, o_full=1, o_enq_ready=0; a 5th command E is held off.
REQ-033 Scenario: full queue, i_issue_ready=1 for 4 cycles -> commands issue A,B,C,D in order, then o_empty=1 and o_issue_valid=0.
REQ-034 Scenario: o_count=2, enqueue and dequeue in the same cycle for 6 cycles -> o_count stays 2, pointers wrap past 3, and order is preserved.
REQ-035 Scenario: o_count=3 with i_flush=1 and i_enq_valid=1 -> o_issue_valid=0 and o_enq_ready=0 in that cycle, and o_count=0 next cycle.
REQ-036 Scenario: rst pulsed high mid-stream with o_count=2 -> o_count=0 and o_issue_valid=0 before the next clk edge.
REQ-037 Scenario: INT_ISSUE_BYPASS_EN defined, empty queue, enqueue X with i_issue_ready=1 -> o_issue_valid=1 and command X in the same cycle, o_count remains 0; when the macro is undefined, X issues one cycle later.

Source files
------------

// File: rtl/int_issue_queue_if.sv
// rtl/int_issue_queue_if.sv - command type package and enqueue/issue handshake interface
package int_issue_pkg;
  typedef struct packed {
    logic [3:0]  opcode;
    logic [4:0]  rd;
    logic [15:0] imm;
  } execution_command_t;
endpackage

interface int_issue_queue_if #(parameter int DEPTH = 4);
  import int_issue_pkg::*;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic               i_enq_valid;
  logic               o_enq_ready;
  execution_command_t i_enq_command;
  logic               i_flush;
  logic               o_issue_valid;
  execution_command_t o_issue_command;
  logic               i_issue_ready;
  logic [CNT_W-1:0]   o_count;
  logic               o_full;
  logic               o_empty;

  modport slave (
    input  i_enq_valid, i_enq_command, i_flush, i_issue_ready,
    output o_enq_ready, o_issue_valid, o_issue_command, o_count, o_full, o_empty
  );

  modport master (
    output i_enq_valid, i_enq_command, i_flush, i_issue_ready,
    input  o_enq_ready, o_issue_valid, o_issue_command, o_count, o_full, o_empty
  );
endinterface

// File: rtl/int_issue_queue.sv
// rtl/int_issue_queue.sv - circular integer issue queue with flush
// Optional same-cycle empty-queue bypass enabled by defining INT_ISSUE_BYPASS_EN.
module int_issue_queue
  import int_issue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  int_issue_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  execution_command_t mem_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               live_q;
  logic               full, empty, enq_ready, issue_valid;
  logic               write_en, pop_en, bypass_hit;
  execution_command_t issue_cmd;

  always_comb begin
    full        = (count_q == CNT_W'(DEPTH));
    empty       = (count_q == '0);
    // live_q holds ready low until the first edge after reset releases
    enq_ready   = live_q && !full && !bus.i_flush;
    bypass_hit  = 1'b0;
    issue_valid = !empty && !bus.i_flush;
    issue_cmd   = mem_q[head_q];
`ifdef INT_ISSUE_BYPASS_EN
    if (live_q && empty && bus.i_enq_valid && !bus.i_flush) begin
      issue_valid = 1'b1;
      issue_cmd   = bus.i_enq_command;
      bypass_hit  = bus.i_issue_ready;
    end
`endif
    write_en = bus.i_enq_valid && enq_ready && !bypass_hit;
    pop_en   = issue_valid && bus.i_issue_ready && !bypass_hit;

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (write_en) tail_d = tail_q + PTR_W'(1);
    if (pop_en)   head_d = head_q + PTR_W'(1);
    if (write_en && !pop_en)      count_d = count_q + CNT_W'(1);
    else if (pop_en && !write_en) count_d = count_q - CNT_W'(1);
    if (bus.i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      live_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      live_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (write_en) mem_q[tail_q] <= bus.i_enq_command;
  end

  assign bus.o_enq_ready     = enq_ready;
  assign bus.o_issue_valid   = issue_valid;
  assign bus.o_issue_command = issue_cmd;
  assign bus.o_count         = count_q;
  assign bus.o_full          = full;
  assign bus.o_empty         = empty;
endmodule
